// File: rtl/mat_pack.sv
// mat_pack: packs row-major 32-bit words into an MxN matrix; output_z_stb rises the cycle after the last word.
// Backpressure: input_a_ack drops while the matrix is held; MAT_PACK_DOUBLE_BUF_EN adds a back bank so filling overlaps presenting.
module mat_pack #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                input_a,
  input  logic                       input_a_stb,
  output logic                       input_a_ack,
  output logic [M-1:0][N-1:0][31:0]  output_z,
  output logic                       output_z_stb,
  input  logic                       output_z_ack
);

  localparam int E  = M * N;
  localparam int KW = (E > 1) ? $clog2(E) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(E - 1);

  logic [KW-1:0]       k;
  logic [E-1:0][31:0]  front;
  logic                in_xfer;
  logic                last_word;

  assign in_xfer   = input_a_stb & input_a_ack;
  assign last_word = in_xfer && (k == K_LAST);
  // Flat element index k maps to (k/N, k%N) because output_z is row-major packed.
  assign output_z  = front;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k <= '0;
    end else if (in_xfer) begin
      k <= last_word ? '0 : k + 1'b1;
    end
  end

`ifdef MAT_PACK_DOUBLE_BUF_EN

  logic [E-1:0][31:0]  back;
  logic [E-1:0][31:0]  back_nxt;
  logic                back_full;
  logic                back_full_nxt;
  logic                out_xfer;

  assign out_xfer = output_z_stb & output_z_ack;

  // back_nxt includes the word being written this edge, so a completed matrix loads whole.
  always_comb begin
    back_nxt = back;
    if (in_xfer) begin
      back_nxt[k] = input_a;
    end
  end

  always_comb begin
    back_full_nxt = back_full;
    if (last_word && output_z_stb && !out_xfer) begin
      back_full_nxt = 1'b1;
    end else if (out_xfer) begin
      back_full_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      back         <= '0;
      front        <= '0;
      back_full    <= 1'b0;
      output_z_stb <= 1'b0;
      input_a_ack  <= 1'b0;
    end else begin
      back        <= back_nxt;
      back_full   <= back_full_nxt;
      input_a_ack <= !back_full_nxt;
      if (last_word && (!output_z_stb || out_xfer)) begin
        front        <= back_nxt;
        output_z_stb <= 1'b1;
      end else if (out_xfer && back_full) begin
        front <= back;
      end else if (out_xfer) begin
        output_z_stb <= 1'b0;
      end
    end
  end

`else

  typedef enum logic {
    FILL,
    PRESENT
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FILL;
      front        <= '0;
      output_z_stb <= 1'b0;
      input_a_ack  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          input_a_ack <= 1'b1;
          if (in_xfer) begin
            front[k] <= input_a;
            if (last_word) begin
              state        <= PRESENT;
              input_a_ack  <= 1'b0;
              output_z_stb <= 1'b1;
            end
          end
        end
        PRESENT: begin
          if (output_z_ack) begin
            state        <= FILL;
            output_z_stb <= 1'b0;
            input_a_ack  <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_mat_pack.sv
// Directed bench for mat_pack at M=N=2; double-buffer steps build when MAT_PACK_DOUBLE_BUF_EN is defined.
module tb_mat_pack;
  localparam int M = 2;
  localparam int N = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [31:0]               input_a;
  logic                      input_a_stb;
  logic                      input_a_ack;
  logic [M-1:0][N-1:0][31:0] output_z;
  logic                      output_z_stb;
  logic                      output_z_ack;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W0 = 32'h3F80_0000;
  localparam logic [31:0] W1 = 32'h4000_0000;
  localparam logic [31:0] W2 = 32'h4040_0000;
  localparam logic [31:0] W3 = 32'h4080_0000;
  localparam logic [31:0] W4 = 32'h40A0_0000;
  localparam logic [31:0] W5 = 32'h40C0_0000;
  localparam logic [31:0] W6 = 32'h40E0_0000;
  localparam logic [31:0] W7 = 32'h4100_0000;

  mat_pack #(.M(M), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] w [4];
    w[0] = W0; w[1] = W1; w[2] = W2; w[3] = W3;
    rst          = 1'b0;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    tick();
    tick();
    chk("rst_ack", input_a_ack, 0);
    chk("rst_stb", output_z_stb, 0);
    chk("rst_z", output_z, 0);
    rst = 1'b1;
    tick();
    chk("ack_rise", input_a_ack, 1);

`ifdef MAT_PACK_DOUBLE_BUF_EN
    begin
      int xc [3];
      int nx;
      logic [127:0] mz;
      nx = 0;
      mz = '0;
      xc[0] = 0; xc[1] = 0; xc[2] = 0;
      output_z_ack = 1'b1;
      input_a_stb  = 1'b1;
      input_a      = 32'd1;
      for (int c = 1; c <= 16; c++) begin
        @(negedge clk);
        if (output_z_stb && output_z_ack) begin
          if (nx < 3) xc[nx] = c;
          if (nx == 0) mz = output_z;
          nx++;
        end
        if (c <= 12) chk("db_ack_steady", input_a_ack, 1);
        tick();
        if (c < 12) input_a = 32'(c + 1);
        else input_a_stb = 1'b0;
      end
      chk("db_xfer_count", nx, 3);
      chk("db_xfer0_cycle", xc[0], 5);
      chk("db_xfer1_cycle", xc[1], 9);
      chk("db_xfer2_cycle", xc[2], 13);
      chk("db_first_z", mz, {32'd4, 32'd3, 32'd2, 32'd1});
    end

    output_z_ack = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    input_a_stb = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      input_a = 32'h100 + 32'(i);
      tick();
    end
    input_a_stb = 1'b0;
    chk("db_full_ack", input_a_ack, 0);
    chk("db_full_stb", output_z_stb, 1);
    chk("db_full_z", output_z, {32'h104, 32'h103, 32'h102, 32'h101});
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk("db_swap_stb", output_z_stb, 1);
    chk("db_swap_z", output_z, {32'h108, 32'h107, 32'h106, 32'h105});
    chk("db_swap_ack", input_a_ack, 1);
`else
    input_a_stb = 1'b1;
    input_a = W0; tick();
    input_a = W1; tick();
    input_a = W2; tick();
    chk("fill_stb_early", output_z_stb, 0);
    input_a = W3; tick();
    chk("fill_stb", output_z_stb, 1);
    chk("fill_z", output_z, {W3, W2, W1, W0});
    chk("fill_ack", input_a_ack, 0);

    input_a = 32'hDEAD_BEEF;
    repeat (10) tick();
    chk("stall_z", output_z, {W3, W2, W1, W0});
    chk("stall_stb", output_z_stb, 1);
    chk("stall_ack", input_a_ack, 0);
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk("drain_stb", output_z_stb, 0);
    chk("drain_ack", input_a_ack, 1);
    chk("drain_z_hold", output_z, {W3, W2, W1, W0});
    tick();
    chk("reload_z", output_z, {W3, W2, W1, 32'hDEAD_BEEF});

    input_a = 32'h1111_1111;
    tick();
    input_a_stb = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_z", output_z, 0);
    chk("async_stb", output_z_stb, 0);
    chk("async_ack", input_a_ack, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("rerst_ack", input_a_ack, 1);

    output_z_ack = 1'b1;
    input_a_stb  = 1'b1;
    input_a = W4; tick();
    input_a = W5; tick();
    input_a = W6; tick();
    input_a = W7; tick();
    input_a_stb = 1'b0;
    chk("refill_stb", output_z_stb, 1);
    chk("refill_z", output_z, {W7, W6, W5, W4});
    tick();
    output_z_ack = 1'b0;
    chk("refill_drain_stb", output_z_stb, 0);
    chk("refill_drain_ack", input_a_ack, 1);

    for (int i = 0; i < 4; i++) begin
      input_a_stb = 1'b1;
      input_a     = w[i];
      tick();
      chk("bubble_stb", output_z_stb, (i == 3) ? 1 : 0);
      input_a_stb = 1'b0;
      input_a     = 32'hBAD0_0000;
      tick();
    end
    chk("bubble_z", output_z, {W3, W2, W1, W0});
    chk("bubble_ack", input_a_ack, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
